gray_fifo_ctrl: RTL and testbench

GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

---
 rtl/gray_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_gray_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_fifo_ctrl.sv
// ============================================================================
// Module  : gray_fifo_ctrl
// Brief   : Single-clock FIFO pointer/flag controller with Gray-coded pointers,
//           registered full/empty/count and sticky overflow/underflow.
//           Optional almost_full/almost_empty via macro GRAY_FIFO_ALMOST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_fifo_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int ALMOST_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef GRAY_FIFO_ALMOST_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDR_WIDTH:0] r_wr_bin;
    logic [ADDR_WIDTH:0] r_rd_bin;
    logic [ADDR_WIDTH:0] r_wr_gray;
    logic [ADDR_WIDTH:0] r_rd_gray;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDR_WIDTH:0] w_wr_bin_nxt;
    logic [ADDR_WIDTH:0] w_rd_bin_nxt;
    logic [ADDR_WIDTH:0] w_wr_gray_nxt;
    logic [ADDR_WIDTH:0] w_rd_gray_nxt;
    logic                w_full_nxt;
    logic                w_empty_nxt;
    logic [ADDR_WIDTH:0] w_count_nxt;

    // Acceptance looks only at registered flags; reset masks the strobes.
    assign w_wr_acc = wr_req & ~r_full  & ~rst;
    assign w_rd_acc = rd_req & ~r_empty & ~rst;

    assign w_wr_bin_nxt  = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    assign w_rd_bin_nxt  = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    assign w_wr_gray_nxt = bin2gray(w_wr_bin_nxt);
    assign w_rd_gray_nxt = bin2gray(w_rd_bin_nxt);
    assign w_count_nxt   = w_wr_bin_nxt - w_rd_bin_nxt;

    // In Gray code a full wrap apart means the top two bits differ, rest equal.
    assign w_empty_nxt = (w_wr_gray_nxt == w_rd_gray_nxt);
    assign w_full_nxt  = (w_wr_gray_nxt == {~w_rd_gray_nxt[ADDR_WIDTH:ADDR_WIDTH-1],
                                             w_rd_gray_nxt[ADDR_WIDTH-2:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bin    <= '0;
            r_rd_bin    <= '0;
            r_wr_gray   <= '0;
            r_rd_gray   <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_bin    <= w_wr_bin_nxt;
            r_rd_bin    <= w_rd_bin_nxt;
            r_wr_gray   <= w_wr_gray_nxt;
            r_rd_gray   <= w_rd_gray_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            r_overflow  <= r_overflow  | (wr_req & r_full);
            r_underflow <= r_underflow | (rd_req & r_empty);
        end
    end

`ifdef GRAY_FIFO_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] c_af_lvl = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - ALMOST_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ae_lvl = (ADDR_WIDTH+1)'(ALMOST_THRESH);

    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= c_af_lvl);
            r_almost_empty <= (w_count_nxt <= c_ae_lvl);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    assign wr_en       = w_wr_acc;
    assign rd_en       = w_rd_acc;
    assign wr_addr     = r_wr_bin[ADDR_WIDTH-1:0];
    assign rd_addr     = r_rd_bin[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = r_wr_gray;
    assign rd_ptr_gray = r_rd_gray;
    assign full        = r_full;
    assign empty       = r_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_gray_fifo_ctrl.sv
// ============================================================================
// Module  : tb_gray_fifo_ctrl
// Brief   : Scoreboard bench for gray_fifo_ctrl (ADDR_WIDTH=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] wr_ptr_gray, rd_ptr_gray, count;
    logic       full, empty, overflow, underflow;
`ifdef GRAY_FIFO_ALMOST_EN
    logic       almost_full, almost_empty;
`endif

    gray_fifo_ctrl #(.ADDR_WIDTH(4), .ALMOST_THRESH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef GRAY_FIFO_ALMOST_EN
        ,
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       comb;
        logic       state;
        logic       step;
        logic       lit;
        logic       wen, ren;
        logic [3:0] wa, ra;
        logic [4:0] wg, rg, cnt;
        logic       full, empty, ovf, unf, af, ae;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: binary pointers, flags derived from occupancy.
    logic [4:0] m_wr, m_rd;
    logic       m_ovf, m_unf;
    bit         m_known = 0;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic cycle(input bit w, input bit r, input bit rs, input bit step,
                         input bit lit, input logic [4:0] lcnt, input logic [4:0] lwg,
                         input logic [4:0] lrg, input logic lf, input logic le);
        exp_t       e;
        logic [4:0] cnt;
        logic       mf, me;
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        rst    = rs;
        #1;
        cnt = m_wr - m_rd;
        mf  = (cnt == 5'd16);
        me  = (cnt == 5'd0);
        e       = '0;
        e.comb  = 1'b1;
        e.state = m_known;
        e.step  = step;
        e.wen   = !rs && w && !mf;
        e.ren   = !rs && r && !me;
        e.wa    = m_wr[3:0];
        e.ra    = m_rd[3:0];
        e.wg    = gray(m_wr);
        e.rg    = gray(m_rd);
        e.cnt   = cnt;
        e.full  = mf;
        e.empty = me;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.af    = (cnt >= 5'd14);
        e.ae    = (cnt <= 5'd2);
        q.push_back(e);
        if (lit) begin
            e       = '0;
            e.lit   = 1'b1;
            e.cnt   = lcnt;
            e.wg    = lwg;
            e.rg    = lrg;
            e.full  = lf;
            e.empty = le;
            q.push_back(e);
        end
        @(posedge clk);
        if (rs) begin
            m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0; m_known = 1;
        end else begin
            m_ovf = m_ovf | (w && mf);
            m_unf = m_unf | (r && me);
            if (w && !mf) m_wr = m_wr + 5'd1;
            if (r && !me) m_rd = m_rd + 5'd1;
        end
    endtask

    task automatic op(input bit w, input bit r);
        cycle(w, r, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic lit(input logic [4:0] c, input logic [4:0] wg, input logic [4:0] rg,
                       input logic f, input logic e);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c, wg, rg, f, e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops each expected record and compares against the live outputs.
    initial begin : p_monitor
        exp_t       e;
        logic [4:0] prev_wg = '0, prev_rg = '0;
        forever begin
            wait (q.size() > 0);
            e = q.pop_front();
            if (e.lit) begin
                chk("lit_count", 32'(count), 32'(e.cnt));
                chk("lit_wr_gray", 32'(wr_ptr_gray), 32'(e.wg));
                chk("lit_rd_gray", 32'(rd_ptr_gray), 32'(e.rg));
                chk("lit_full", 32'(full), 32'(e.full));
                chk("lit_empty", 32'(empty), 32'(e.empty));
            end else begin
                chk("wr_en", 32'(wr_en), 32'(e.wen));
                chk("rd_en", 32'(rd_en), 32'(e.ren));
                if (e.state) begin
                    chk("wr_addr", 32'(wr_addr), 32'(e.wa));
                    chk("rd_addr", 32'(rd_addr), 32'(e.ra));
                    chk("wr_gray", 32'(wr_ptr_gray), 32'(e.wg));
                    chk("rd_gray", 32'(rd_ptr_gray), 32'(e.rg));
                    chk("count", 32'(count), 32'(e.cnt));
                    chk("full", 32'(full), 32'(e.full));
                    chk("empty", 32'(empty), 32'(e.empty));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    chk("underflow", 32'(underflow), 32'(e.unf));
`ifdef GRAY_FIFO_ALMOST_EN
                    chk("almost_full", 32'(almost_full), 32'(e.af));
                    chk("almost_empty", 32'(almost_empty), 32'(e.ae));
`endif
                end
                if (e.step) begin
                    chk("wr_gray_1bit", 32'($countones(wr_ptr_gray ^ prev_wg)), 32'd1);
                    chk("rd_gray_1bit", 32'($countones(rd_ptr_gray ^ prev_rg)), 32'd1);
                end
                prev_wg = wr_ptr_gray;
                prev_rg = rd_ptr_gray;
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        // Reset, then hand-computed reset state.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        lit(5'd0, 5'b00000, 5'b00000, 1'b0, 1'b1);

        // Fill.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0);
        lit(5'd5, 5'b00111, 5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) op(1'b1, 1'b0);
        lit(5'd16, 5'b11000, 5'b00000, 1'b1, 1'b0);
        op(1'b1, 1'b0);

        // Drain.
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1);
        lit(5'd0, 5'b11000, 5'b11000, 1'b0, 1'b1);
        op(1'b0, 1'b1);

        // Empty with both requests: write only.
        op(1'b1, 1'b1);

        // Build to 7, then 20 simultaneous cycles across pointer wrap.
        for (int i = 0; i < 6; i++) op(1'b1, 1'b0);
        lit(5'd7, 5'b11100, 5'b11000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, 1'b0, (i > 0), 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        lit(5'd7, 5'b01110, 5'b00110, 1'b0, 1'b0);

        // Full with both requests: read only.
        for (int i = 0; i < 9; i++) op(1'b1, 1'b0);
        op(1'b1, 1'b1);
        lit(5'd15, 5'b11110, 5'b00111, 1'b0, 1'b0);

        // Down to 9, then reset with requests active.
        for (int i = 0; i < 6; i++) op(1'b0, 1'b1);
        lit(5'd9, 5'b11110, 5'b01110, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        op(1'b0, 1'b0);
        lit(5'd0, 5'b00000, 5'b00000, 1'b0, 1'b1);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_queue: actual=%0d pending expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
